// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU operation codes and the
// ID/EX and EX/MEM pipeline register bundles.
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int RBITS = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_CMP = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic [2:0]       alu_control;
        logic [XLEN-1:0]  src_a;
        logic [XLEN-1:0]  src_b;
        logic             reg_write;
        logic [RBITS-1:0] write_reg;
        logic             valid;
    } idex_t;

    typedef struct packed {
        logic [XLEN-1:0]  alu_out;
        logic             zero;
        logic             reg_write;
        logic [RBITS-1:0] write_reg;
        logic             valid;
        logic             illegal;
    } exmem_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; undefined codes yield 0 and flag illegal.
module alu
    import mips_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_control,
    output logic [WIDTH-1:0] o_result,
    output logic             o_illegal
);

    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_control)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_CMP: o_result = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
            // 100, 101 and unknown codes all land here
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, and EX/MEM register with stall/flush
// handling driven by the hazard unit.
module ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int REGBITS = RBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ALUControlD,
    input  logic [WIDTH-1:0]   SrcAD,
    input  logic [WIDTH-1:0]   SrcBD,
    input  logic [WIDTH-1:0]   SignImmD,
    input  logic               ALUSrcD,
    input  logic               RegWriteD,
    input  logic [REGBITS-1:0] WriteRegD,
    input  logic               ValidD,
    input  logic               StallE,
    input  logic               FlushE,
    output logic               RegWriteE,
    output logic [REGBITS-1:0] WriteRegE,
    output logic [WIDTH-1:0]   ALUOutM,
    output logic               ZeroM,
    output logic               RegWriteM,
    output logic [REGBITS-1:0] WriteRegM,
    output logic               ValidM,
    output logic               IllegalM
);

    idex_t            r_idex;
    idex_t            w_idex_next;
    exmem_t           r_exmem;
    exmem_t           w_exmem_next;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_illegal;

    // Flush outranks stall so a bubble can replace a held instruction.
    always_comb begin
        w_idex_next = r_idex;
        if (FlushE) begin
            w_idex_next = '0;
        end else if (!StallE) begin
            w_idex_next.alu_control = ALUControlD;
            w_idex_next.src_a       = SrcAD;
            w_idex_next.src_b       = ALUSrcD ? SignImmD : SrcBD;
            w_idex_next.reg_write   = RegWriteD;
            w_idex_next.write_reg   = WriteRegD;
            w_idex_next.valid       = ValidD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_idex <= '0;
        else       r_idex <= w_idex_next;
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .i_a       (r_idex.src_a),
        .i_b       (r_idex.src_b),
        .i_control (r_idex.alu_control),
        .o_result  (w_alu_result),
        .o_illegal (w_alu_illegal)
    );

    // A held E instruction must not also advance, so M takes a bubble;
    // with FlushE also high, the pre-edge E contents still move on.
    always_comb begin
        w_exmem_next = '0;
        if (!(StallE && !FlushE)) begin
            w_exmem_next.alu_out   = w_alu_result;
            w_exmem_next.zero      = (w_alu_result == '0);
            w_exmem_next.reg_write = r_idex.reg_write & r_idex.valid & ~w_alu_illegal;
            w_exmem_next.write_reg = r_idex.write_reg;
            w_exmem_next.valid     = r_idex.valid;
            w_exmem_next.illegal   = w_alu_illegal & r_idex.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_exmem <= '0;
        else       r_exmem <= w_exmem_next;
    end

    assign RegWriteE = r_idex.reg_write & r_idex.valid;
    assign WriteRegE = r_idex.write_reg;
    assign ALUOutM   = r_exmem.alu_out;
    assign ZeroM     = r_exmem.zero;
    assign RegWriteM = r_exmem.reg_write;
    assign WriteRegM = r_exmem.write_reg;
    assign ValidM    = r_exmem.valid;
    assign IllegalM  = r_exmem.illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomised stimulus for ex_stage, checked every cycle against
// a slot-level pipeline model plus hand-computed literal expectations.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  ALUControlD;
    logic [31:0] SrcAD, SrcBD, SignImmD;
    logic        ALUSrcD, RegWriteD, ValidD, StallE, FlushE;
    logic [4:0]  WriteRegD;
    logic        RegWriteE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUOutM;
    logic        ZeroM, RegWriteM, ValidM, IllegalM;
    logic [4:0]  WriteRegM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .ALUControlD(ALUControlD), .SrcAD(SrcAD),
        .SrcBD(SrcBD), .SignImmD(SignImmD), .ALUSrcD(ALUSrcD),
        .RegWriteD(RegWriteD), .WriteRegD(WriteRegD), .ValidD(ValidD),
        .StallE(StallE), .FlushE(FlushE), .RegWriteE(RegWriteE),
        .WriteRegE(WriteRegE), .ALUOutM(ALUOutM), .ZeroM(ZeroM),
        .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .ValidM(ValidM),
        .IllegalM(IllegalM)
    );

    // Model: one instruction slot per stage, described by what it means.
    bit          model_ok = 0;
    bit          e_valid, e_rw;
    logic [4:0]  e_wr;
    logic [2:0]  e_op;
    logic [31:0] e_a, e_b;
    bit          m_valid, m_rw, m_ill, m_zero;
    logic [4:0]  m_wr;
    logic [31:0] m_out;

    function automatic void alu_ref(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output bit ill);
        ill = 0;
        r   = 0;
        if (op == 3'b010)      r = a + b;
        else if (op == 3'b110) r = a - b;
        else if (op == 3'b000) r = a & b;
        else if (op == 3'b001) r = a | b;
        else if (op == 3'b111) r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        else if (op == 3'b011) r = (a == b) ? 32'd1 : 32'd0;
        else                   ill = 1;
    endfunction

    always @(posedge clk) begin
        logic [31:0] r;
        bit ill;
        if (reset) begin
            model_ok = 1;
            e_valid = 0; e_rw = 0; e_wr = 0; e_op = 0; e_a = 0; e_b = 0;
            m_valid = 0; m_rw = 0; m_ill = 0; m_zero = 0; m_wr = 0; m_out = 0;
        end else begin
            if (StallE && !FlushE) begin
                m_valid = 0; m_rw = 0; m_ill = 0;
            end else begin
                alu_ref(e_op, e_a, e_b, r, ill);
                m_out   = r;
                m_zero  = (r == 0);
                m_valid = e_valid;
                m_ill   = ill && e_valid;
                m_rw    = e_rw && e_valid && !ill;
                m_wr    = e_wr;
            end
            if (FlushE) begin
                e_valid = 0; e_rw = 0;
            end else if (!StallE) begin
                e_valid = ValidD; e_rw = RegWriteD; e_wr = WriteRegD;
                e_op = ALUControlD; e_a = SrcAD; e_b = ALUSrcD ? SignImmD : SrcBD;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("ValidM", 32'(ValidM), 32'(m_valid));
            chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
            chk("IllegalM", 32'(IllegalM), 32'(m_ill));
            chk("RegWriteE", 32'(RegWriteE), 32'(e_valid && e_rw));
            if (e_valid) chk("WriteRegE", 32'(WriteRegE), 32'(e_wr));
            if (m_valid) begin
                chk("ALUOutM", ALUOutM, m_out);
                chk("ZeroM", 32'(ZeroM), 32'(m_zero));
                chk("WriteRegM", 32'(WriteRegM), 32'(m_wr));
            end
        end
    end

    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic src, input logic rw,
                        input logic [4:0] wr, input logic v, input logic st, input logic fl);
        ALUControlD = op; SrcAD = a; SrcBD = b; SignImmD = imm; ALUSrcD = src;
        RegWriteD = rw; WriteRegD = wr; ValidD = v; StallE = st; FlushE = fl;
        @(negedge clk);
        $display("step op=%b a=%h b=%h imm=%h src=%b st=%b fl=%b rst=%b -> E rw=%b wr=%0d | M out=%h z=%b rw=%b wr=%0d v=%b ill=%b",
                 op, a, b, imm, src, st, fl, reset, RegWriteE, WriteRegE,
                 ALUOutM, ZeroM, RegWriteM, WriteRegM, ValidM, IllegalM);
    endtask

    task automatic chk_m(input string nm, input logic [31:0] out, input logic z,
                         input logic rw, input logic [4:0] wr, input logic v, input logic ill);
        chk({nm, ".out"}, ALUOutM, out);
        chk({nm, ".zero"}, 32'(ZeroM), 32'(z));
        chk({nm, ".rw"}, 32'(RegWriteM), 32'(rw));
        chk({nm, ".wr"}, 32'(WriteRegM), 32'(wr));
        chk({nm, ".valid"}, 32'(ValidM), 32'(v));
        chk({nm, ".ill"}, 32'(IllegalM), 32'(ill));
    endtask

    task automatic chk_all_zero(input string nm);
        chk_m(nm, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk({nm, ".rwE"}, 32'(RegWriteE), 32'd0);
        chk({nm, ".wrE"}, 32'(WriteRegE), 32'd0);
    endtask

    initial begin
        reset = 1;
        step(3'b010, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        step(3'b010, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        chk_all_zero("reset");
        reset = 0;
        step(3'b010, 32'd7, 32'd5, 32'd0, 0, 1, 5'd3, 1, 0, 0);           // add
        step(3'b110, 32'd0, 32'd99, 32'd1, 1, 1, 5'd4, 1, 0, 0);          // sub imm
        chk_m("add", 32'd12, 0, 1, 5'd3, 1, 0);
        step(3'b110, 32'd9, 32'd9, 32'd0, 0, 1, 5'd5, 1, 0, 0);
        chk_m("subwrap", 32'hFFFF_FFFF, 0, 1, 5'd4, 1, 0);
        step(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 5'd6, 1, 0, 0);
        chk_m("subzero", 32'd0, 1, 1, 5'd5, 1, 0);
        step(3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1, 5'd7, 1, 0, 0);
        chk_m("slt_neg", 32'd1, 0, 1, 5'd6, 1, 0);
        step(3'b011, 32'h55, 32'h55, 32'd0, 0, 1, 5'd8, 1, 0, 0);
        chk_m("slt_swap", 32'd0, 1, 1, 5'd7, 1, 0);
        step(3'b001, 32'hF0, 32'h0F, 32'd0, 0, 1, 5'd9, 1, 0, 0);         // or enters E
        chk_m("cmp", 32'd1, 0, 1, 5'd8, 1, 0);
        step(3'b000, 32'd3, 32'd3, 32'd0, 0, 1, 5'd10, 1, 1, 0);
        chk("stall1.validM", 32'(ValidM), 32'd0);
        chk("stall1.rwM", 32'(RegWriteM), 32'd0);
        chk("stall1.wrE", 32'(WriteRegE), 32'd9);
        step(3'b000, 32'd3, 32'd3, 32'd0, 0, 1, 5'd10, 1, 1, 0);
        chk("stall2.validM", 32'(ValidM), 32'd0);
        chk("stall2.rwE", 32'(RegWriteE), 32'd1);
        step(3'b000, 32'hFF, 32'h3C, 32'd0, 0, 1, 5'd10, 1, 0, 0);
        chk_m("or_after_stall", 32'hFF, 0, 1, 5'd9, 1, 0);
        step(3'b010, 32'd1, 32'd1, 32'd0, 0, 1, 5'd11, 1, 1, 1);          // flush+stall
        chk("flush.rwE", 32'(RegWriteE), 32'd0);
        chk_m("flush_m", 32'h3C, 0, 1, 5'd10, 1, 0);
        step(3'b100, 32'd3, 32'd4, 32'd0, 0, 1, 5'd12, 1, 0, 0);
        chk("bubble.validM", 32'(ValidM), 32'd0);
        step(3'b010, 32'd2, 32'd2, 32'd0, 0, 1, 5'd13, 1, 0, 0);
        chk_m("illegal", 32'd0, 1, 0, 5'd12, 1, 1);
        step(3'b010, 32'd5, 32'd5, 32'd0, 0, 1, 5'd14, 1, 0, 0);
        chk_m("add2", 32'd4, 0, 1, 5'd13, 1, 0);
        reset = 1;
        step(3'b010, 32'd5, 32'd5, 32'd0, 0, 1, 5'd15, 1, 1, 0);
        chk_all_zero("midreset");
        reset = 0;
        step(3'b010, 32'd1, 32'd2, 32'd0, 0, 1, 5'd1, 1, 0, 0);
        step(3'b010, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 0, 0, 0);
        chk_m("post_reset", 32'd3, 0, 1, 5'd1, 1, 0);
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            reset = ($urandom_range(0, 39) == 0);
            step(3'($urandom_range(0, 7)), a, b, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end
        reset = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
